// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - client and memory-side signal bundle of the I/D memory port arbiter
interface mem_port_arbiter_if;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        timeout_err;

    // Arbiter view: serves client requests, drives the physical memory strobes.
    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, d_byte_enable,
        input  mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, timeout_err
    );

    // Environment view: the two requesters plus the memory itself.
    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, d_byte_enable,
        output mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between I-fetch and load/store
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state;
    logic        last_grant_d;
    logic [15:0] wait_cnt;
    logic [15:0] wait_inc;
    logic        i_req;
    logic        d_req;
    logic        pick_i;
    logic        pick_d;

    assign i_req  = bus.i_read;
    assign d_req  = bus.d_read | bus.d_write;
    // Under contention the side that did not win last time goes first.
    assign pick_i = i_req & (~d_req | last_grant_d);
    assign pick_d = d_req & (~i_req | ~last_grant_d);

    assign wait_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

    // Completion is forwarded in the same cycle mem_resp arrives; reset suppresses it.
    assign bus.i_resp  = rst & bus.mem_resp & (state == GRANT_I);
    assign bus.d_resp  = rst & bus.mem_resp & (state == GRANT_D);
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state               <= IDLE;
            last_grant_d        <= 1'b1;
            wait_cnt            <= 16'd0;
            bus.mem_read        <= 1'b0;
            bus.mem_write       <= 1'b0;
            bus.mem_address     <= 32'd0;
            bus.mem_wdata       <= 32'd0;
            bus.mem_byte_enable <= 4'd0;
            bus.timeout_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_i) begin
                        state               <= GRANT_I;
                        last_grant_d        <= 1'b0;
                        wait_cnt            <= 16'd0;
                        bus.mem_read        <= 1'b1;
                        bus.mem_write       <= 1'b0;
                        bus.mem_address     <= bus.i_address;
                        bus.mem_wdata       <= 32'd0;
                        bus.mem_byte_enable <= 4'hF;
                    end else if (pick_d) begin
                        // A simultaneous read and write is carried out as the write.
                        state               <= GRANT_D;
                        last_grant_d        <= 1'b1;
                        wait_cnt            <= 16'd0;
                        bus.mem_read        <= ~bus.d_write;
                        bus.mem_write       <= bus.d_write;
                        bus.mem_address     <= bus.d_address;
                        bus.mem_wdata       <= bus.d_wdata;
                        bus.mem_byte_enable <= bus.d_write ? bus.d_byte_enable : 4'hF;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (bus.mem_resp) begin
                        state         <= IDLE;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                    end else begin
                        // A stuck transaction is only flagged, never aborted.
                        wait_cnt <= wait_inc;
                        if (wait_inc >= TIMEOUT_W) begin
                            bus.timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
